// File: rtl/rx_module.sv
// UART receiver: 16x oversampled, 5..8 data bits, optional even parity,
// 1..4 stop bits, with optional FIFO push and overrun reporting.
module rx_module #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int STOP_CONF_W     = 2,
  parameter int DATA_CONF_W     = 2,
  parameter int SAMPLE_COUNT_W  = 4,
  parameter int DATA_COUNTER_W  = 3,
  parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       baud_en_i,
  input  logic                       rx_en_i,
  input  logic [TOTAL_CONF_W-1:0]    rx_conf_i,
  input  logic                       uart_rx_i,
  input  logic                       rx_fifo_en_i,
  input  logic                       rx_fifo_full_i,
  output logic [MAX_UART_DATA_W-1:0] rx_data_o,
  output logic                       rx_done_o,
  output logic                       rx_busy_o,
  output logic                       parity_err_o,
  output logic                       frame_err_o,
  output logic                       overrun_err_o,
  output logic                       rx_fifo_push_o,
  output logic [2:0]                 state_dbg
);

  // Encoding is visible on state_dbg and is part of the debug interface.
  typedef enum logic [2:0] {
    S_RESET       = 3'd0,
    S_IDLE        = 3'd1,
    S_START_CHECK = 3'd2,
    S_RECV_DATA   = 3'd3,
    S_RECV_PARITY = 3'd4,
    S_RECV_STOP   = 3'd5,
    S_DONE        = 3'd6
  } state_t;

  localparam int DATA_LSB = STOP_CONF_W + 1;
  localparam logic [SAMPLE_COUNT_W-1:0] START_CNT = SAMPLE_COUNT_W'(7);
  localparam logic [SAMPLE_COUNT_W-1:0] MID_CNT   = '1;

  state_t                      state;
  logic                        sync_q1;
  logic                        sync_q2;
  logic [SAMPLE_COUNT_W-1:0]   sample_cnt;
  logic [DATA_COUNTER_W-1:0]   bit_cnt;
  logic [STOP_CONF_W-1:0]      stop_cnt;
  logic [TOTAL_CONF_W-1:0]     conf_q;
  logic [MAX_UART_DATA_W-1:0]  data_buf;
  logic                        parity_acc;
  logic                        frame_acc;
  logic                        overrun_q;

  logic                        line;
  logic [DATA_CONF_W-1:0]      conf_data;
  logic [STOP_CONF_W-1:0]      conf_stop;
  logic                        conf_parity;
  logic [DATA_COUNTER_W-1:0]   last_bit;

  assign line        = sync_q2;
  assign conf_data   = conf_q[TOTAL_CONF_W-1:DATA_LSB];
  assign conf_stop   = conf_q[STOP_CONF_W:1];
  assign conf_parity = conf_q[0];
  assign last_bit    = DATA_COUNTER_W'(4) + DATA_COUNTER_W'(conf_data);
  assign state_dbg   = state;

  // The held overrun flag is masked so it reads 0 whenever FIFO mode is off.
  assign overrun_err_o = overrun_q & rx_fifo_en_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= uart_rx_i;
      sync_q2 <= sync_q1;
    end
  end

  // rx_fifo_push_o is a single-cycle strobe coincident with rx_done_o; the
  // consumer must accept it in that cycle, rx_fifo_full_i being the only
  // back-pressure, sampled at Done to choose push versus overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_RESET;
      sample_cnt     <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= '0;
      conf_q         <= '0;
      data_buf       <= '0;
      parity_acc     <= 1'b0;
      frame_acc      <= 1'b0;
      overrun_q      <= 1'b0;
      rx_data_o      <= '0;
      rx_done_o      <= 1'b0;
      rx_busy_o      <= 1'b0;
      parity_err_o   <= 1'b0;
      frame_err_o    <= 1'b0;
      rx_fifo_push_o <= 1'b0;
    end else begin
      rx_done_o      <= 1'b0;
      rx_fifo_push_o <= 1'b0;
      if (baud_en_i) begin
        case (state)
          S_RESET: begin
            if (rx_en_i) state <= S_IDLE;
          end
          S_IDLE: begin
            if (!line) begin
              state      <= S_START_CHECK;
              sample_cnt <= '0;
              conf_q     <= rx_conf_i;
              rx_busy_o  <= 1'b1;
              data_buf   <= '0;
              bit_cnt    <= '0;
              stop_cnt   <= '0;
              parity_acc <= 1'b0;
              frame_acc  <= 1'b0;
            end
          end
          S_START_CHECK: begin
            if (sample_cnt == START_CNT) begin
              sample_cnt <= '0;
              if (!line) begin
                state <= S_RECV_DATA;
              end else begin
                state     <= S_IDLE;
                rx_busy_o <= 1'b0;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
          S_RECV_DATA: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == MID_CNT) begin
              data_buf[bit_cnt] <= line;
              if (bit_cnt == last_bit) begin
                bit_cnt <= '0;
                state   <= conf_parity ? S_RECV_PARITY : S_RECV_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_RECV_PARITY: begin
            sample_cnt <= sample_cnt + 1'b1;
            // Upper unreceived bits of data_buf are 0, so they do not disturb the XOR.
            if (sample_cnt == MID_CNT) begin
              parity_acc <= line ^ (^data_buf);
              state      <= S_RECV_STOP;
            end
          end
          S_RECV_STOP: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == MID_CNT) begin
              if (!line) frame_acc <= 1'b1;
              if (stop_cnt == conf_stop) begin
                state <= S_DONE;
              end else begin
                stop_cnt <= stop_cnt + 1'b1;
              end
            end
          end
          S_DONE: begin
            rx_done_o      <= 1'b1;
            rx_data_o      <= data_buf;
            parity_err_o   <= parity_acc;
            frame_err_o    <= frame_acc;
            rx_busy_o      <= 1'b0;
            overrun_q      <= rx_fifo_en_i & rx_fifo_full_i;
            rx_fifo_push_o <= rx_fifo_en_i & ~rx_fifo_full_i;
            state          <= rx_en_i ? S_IDLE : S_RESET;
          end
          default: state <= S_RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_module.sv
// Bench for rx_module: directed vector table, hand-written corner sequences
// and randomized frames scored against a frame-level reference model.
module tb_rx_module;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;

  logic       clk;
  logic       rst;
  logic       baud_en;
  logic       rx_en;
  logic [4:0] rx_conf;
  logic       uart_rx;
  logic       fifo_en;
  logic       fifo_full;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       fifo_push;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // {overrun, push, frame_err, parity_err, data}
  logic [11:0] exp_q[$];

  typedef struct {
    logic [4:0] conf;
    logic [7:0] data;
    logic       pbit;
    logic [3:0] stops;
    logic       fen;
    logic       full;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_ovr;
    logic       exp_push;
  } vec_t;

  vec_t vecs[9];

  rx_module dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .baud_en_i      (baud_en),
    .rx_en_i        (rx_en),
    .rx_conf_i      (rx_conf),
    .uart_rx_i      (uart_rx),
    .rx_fifo_en_i   (fifo_en),
    .rx_fifo_full_i (fifo_full),
    .rx_data_o      (rx_data),
    .rx_done_o      (rx_done),
    .rx_busy_o      (rx_busy),
    .parity_err_o   (parity_err),
    .frame_err_o    (frame_err),
    .overrun_err_o  (overrun_err),
    .rx_fifo_push_o (fifo_push),
    .state_dbg      (state_dbg)
  );

  // clock and baud tick (one tick every third clock)
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div = 0;
    baud_en = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == 2) ? 0 : div + 1;
      baud_en = (div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_en) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [4:0] conf, input logic [7:0] data,
                            input logic pbit, input logic [3:0] stops);
    int w;
    int ns;
    w  = 5 + int'(conf[4:3]);
    ns = 1 + int'(conf[2:1]);
    rx_conf = conf;
    send_bit(1'b0);
    check("busy_in_frame", {31'd0, rx_busy}, 32'd1);
    for (int i = 0; i < w; i++) send_bit(data[i]);
    if (conf[0]) send_bit(pbit);
    for (int m = 0; m < ns; m++) send_bit(stops[m]);
    uart_rx = 1'b1;
  endtask

  task automatic check_idle(input string name, input logic [2:0] exp_state, input logic [7:0] exp_data);
    wait_ticks(24);
    check({name, "_busy_after"}, {31'd0, rx_busy}, 32'd0);
    check({name, "_pending_frames"}, exp_q.size(), 32'd0);
    check({name, "_state_after"}, {29'd0, state_dbg}, {29'd0, exp_state});
    check({name, "_data_held"}, {24'd0, rx_data}, {24'd0, exp_data});
    exp_q.delete();
  endtask

  function automatic logic [11:0] model(input logic [4:0] conf, input logic [7:0] data,
                                        input logic pbit, input logic [3:0] stops,
                                        input logic fen, input logic full);
    int w;
    int ns;
    logic [7:0] d;
    logic perr;
    logic ferr;
    w  = 5 + int'(conf[4:3]);
    ns = 1 + int'(conf[2:1]);
    d  = 8'd0;
    for (int i = 0; i < w; i++) d[i] = data[i];
    perr = conf[0] ? (pbit ^ (^d)) : 1'b0;
    ferr = 1'b0;
    for (int m = 0; m < ns; m++) if (!stops[m]) ferr = 1'b1;
    return {fen & full, fen & ~full, ferr, perr, d};
  endfunction

  // scoreboard: every done pulse is matched against the expected queue
  initial begin
    logic [11:0] e;
    logic [11:0] act;
    forever begin
      @(negedge clk);
      if (rx_done) begin
        act = {overrun_err, fifo_push, frame_err, parity_err, rx_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got 0x%0h expected no frame", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL frame_result: got 0x%0h expected 0x%0h", act, e);
          end
        end
      end else if (fifo_push) begin
        n_tests++;
        n_fail++;
        $display("FAIL push_without_done: got push=1 expected push=0");
      end
    end
  end

  initial begin
    logic [4:0]  c;
    logic [7:0]  d;
    logic        p;
    logic [3:0]  s;
    logic        fe;
    logic        fu;
    logic [11:0] e;

    vecs[0] = '{5'b11000, 8'hA5, 1'b0, 4'hF, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'b10011, 8'h41, 1'b1, 4'hF, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'b00000, 8'h15, 1'b0, 4'hE, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{5'b01011, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'b11110, 8'h00, 1'b0, 4'hD, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{5'b00000, 8'hE7, 1'b0, 4'hF, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{5'b11001, 8'h81, 1'b0, 4'hF, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{5'b11000, 8'h3C, 1'b0, 4'hF, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{5'b11000, 8'h3C, 1'b0, 4'hF, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    rx_en = 1'b0;
    rx_conf = 5'd0;
    uart_rx = 1'b1;
    fifo_en = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_done", {31'd0, rx_done}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    check("reset_perr", {31'd0, parity_err}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_ovr", {31'd0, overrun_err}, 32'd0);
    check("reset_push", {31'd0, fifo_push}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, {29'd0, ST_RESET});

    // line activity ignored while disabled
    rst = 1'b0;
    uart_rx = 1'b0;
    wait_ticks(40);
    check("disabled_state", {29'd0, state_dbg}, {29'd0, ST_RESET});
    check("disabled_busy", {31'd0, rx_busy}, 32'd0);
    uart_rx = 1'b1;
    rx_en = 1'b1;
    wait_ticks(4);
    check("enable_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});

    for (int i = 0; i < 9; i++) begin
      fifo_en = vecs[i].fen;
      fifo_full = vecs[i].full;
      exp_q.push_back({vecs[i].exp_ovr, vecs[i].exp_push, vecs[i].exp_ferr,
                       vecs[i].exp_perr, vecs[i].exp_data});
      send_frame(vecs[i].conf, vecs[i].data, vecs[i].pbit, vecs[i].stops);
      check_idle($sformatf("vec%0d", i), ST_IDLE, vecs[i].exp_data);
      if (vecs[i].fen && vecs[i].full) begin
        check("ovr_held", {31'd0, overrun_err}, 32'd1);
        fifo_en = 1'b0;
        @(negedge clk);
        check("ovr_gated_by_fifo_en", {31'd0, overrun_err}, 32'd0);
      end
    end
    fifo_en = 1'b0;
    fifo_full = 1'b0;

    // false start: line low for 4 ticks only
    uart_rx = 1'b0;
    wait_ticks(4);
    check("false_start_busy", {31'd0, rx_busy}, 32'd1);
    check("false_start_state", {29'd0, state_dbg}, {29'd0, ST_START});
    uart_rx = 1'b1;
    check_idle("false_start", ST_IDLE, 8'h3C);

    // rx_en dropped mid-frame: frame completes, then back to Reset
    exp_q.push_back(model(5'b11000, 8'hC3, 1'b0, 4'hF, 1'b0, 1'b0));
    fork
      send_frame(5'b11000, 8'hC3, 1'b0, 4'hF);
      begin
        wait_ticks(60);
        rx_en = 1'b0;
      end
    join
    check_idle("en_drop", ST_RESET, 8'hC3);
    rx_en = 1'b1;
    wait_ticks(4);

    // reset during data bit 3
    rx_conf = 5'b11000;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    uart_rx = 1'b1;
    wait_ticks(8);
    check("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_data", {24'd0, rx_data}, 32'd0);
    check("async_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("async_rst_done", {31'd0, rx_done}, 32'd0);
    check("async_rst_errs", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    check("async_rst_push", {31'd0, fifo_push}, 32'd0);
    check("async_rst_state", {29'd0, state_dbg}, {29'd0, ST_RESET});
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(4);
    exp_q.push_back(model(5'b11000, 8'h5A, 1'b0, 4'hF, 1'b0, 1'b0));
    send_frame(5'b11000, 8'h5A, 1'b0, 4'hF);
    check_idle("after_reset", ST_IDLE, 8'h5A);

    // randomized frames against the reference model
    for (int k = 0; k < 20; k++) begin
      c  = 5'($urandom_range(0, 31));
      d  = 8'($urandom_range(0, 255));
      p  = 1'($urandom_range(0, 1));
      s  = 4'hF;
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, 3)] = 1'b0;
      fe = 1'($urandom_range(0, 1));
      fu = 1'($urandom_range(0, 1));
      fifo_en = fe;
      fifo_full = fu;
      e = model(c, d, p, s, fe, fu);
      exp_q.push_back(e);
      send_frame(c, d, p, s);
      check_idle($sformatf("rand%0d", k), ST_IDLE, e[7:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
